// File: rtl/fp_divider_param_if.sv
// Streaming stb/ack bundle for the parametrised floating-point divider.
// Parameters must match those of the fp_divider_param instance it connects to.
interface fp_divider_param_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic [W-1:0] input_a;
   logic         input_a_stb;
   logic         input_a_ack;
   logic [W-1:0] input_b;
   logic [1:0]   input_rm;
   logic         input_b_stb;
   logic         input_b_ack;
   logic [W-1:0] output_z;
   logic [4:0]   output_z_flags;
   logic         output_z_stb;
   logic         output_z_ack;

   modport master (
      output input_a, input_a_stb, input_b, input_rm, input_b_stb, output_z_ack,
      input  input_a_ack, input_b_ack, output_z, output_z_flags, output_z_stb
   );

   modport slave (
      input  input_a, input_a_stb, input_b, input_rm, input_b_stb, output_z_ack,
      output input_a_ack, input_b_ack, output_z, output_z_flags, output_z_stb
   );
endinterface

// File: rtl/fp_divider_param.sv
// Serial IEEE-754 divider, generic in exponent/fraction width, with four
// rounding modes and {invalid, div_by_zero, overflow, underflow, inexact} flags.
module fp_divider_param #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input logic clk,
   input logic rst,
   fp_divider_param_if.slave bus
);
   localparam int F  = MAN_W;
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int EW = EXP_W + 2;
   localparam int QW = F + 4;
   localparam int RW = F + 2;
   localparam int BIAS_I = 2 ** (EXP_W - 1) - 1;
   localparam logic signed [EW-1:0] BIAS = EW'(BIAS_I);
   localparam logic signed [EW-1:0] EMIN = EW'(1 - BIAS_I);
   localparam logic [W-1:0] QNAN = {1'b1, {EXP_W{1'b1}}, 1'b1, {(F-1){1'b0}}};

   typedef enum logic [3:0] {
      GET_A, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B, DIV_INIT,
      DIVIDE, DIV_DONE, DENORM, ROUND, PACK, PUT_Z
   } state_t;

   state_t state;

   logic             a_ack, b_ack, z_stb;
   logic [W-1:0]     z;
   logic [4:0]       flags;
   logic [W-1:0]     a_word, b_word;
   logic [1:0]       rm;
   logic             a_s, b_s, z_s;
   logic [EXP_W-1:0] a_x, b_x;
   logic [F-1:0]     a_f, b_f;
   logic [F:0]       m_a, m_b, mant;
   logic signed [EW-1:0] a_e, b_e, z_e;
   logic [QW-1:0]    q;
   logic [RW-1:0]    rem;
   logic [6:0]       count;
   logic             g, r, s;
   logic             inexact, underflow;

   logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
   assign a_nan  = (a_x == '1) && (a_f != '0);
   assign b_nan  = (b_x == '1) && (b_f != '0);
   assign a_inf  = (a_x == '1) && (a_f == '0);
   assign b_inf  = (b_x == '1) && (b_f == '0);
   assign a_zero = (a_x == '0) && (a_f == '0);
   assign b_zero = (b_x == '0) && (b_f == '0);
   assign sgn    = a_s ^ b_s;

   logic [RW-1:0] mb_ext, rem_next;
   logic          rem_ge;
   assign mb_ext   = {1'b0, m_b};
   assign rem_ge   = rem >= mb_ext;
   assign rem_next = rem_ge ? ((rem - mb_ext) << 1) : (rem << 1);

   logic       inc, grs;
   logic [F+1:0] sum;
   assign grs = g | r | s;
   always_comb begin
      inc = 1'b0;
      case (rm)
         2'd0: inc = g & (r | s | mant[0]);
         2'd1: inc = 1'b0;
         2'd2: inc = ~z_s & grs;
         2'd3: inc = z_s & grs;
         default: inc = 1'b0;
      endcase
   end
   assign sum = {1'b0, mant} + {{(F+1){1'b0}}, inc};

   logic [EXP_W-1:0] e_field, z_exp;
   logic             sat_max;
   assign e_field = EXP_W'(z_e + BIAS);
   assign z_exp   = mant[F] ? e_field : {EXP_W{1'b0}};
   assign sat_max = (rm == 2'd1) || (rm == 2'd2 && z_s) || (rm == 2'd3 && !z_s);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= GET_A;
         a_ack <= 1'b0;
         b_ack <= 1'b0;
         z_stb <= 1'b0;
         z     <= '0;
         flags <= '0;
      end else begin
         case (state)
            GET_A: begin
               a_ack <= 1'b1;
               if (a_ack && bus.input_a_stb) begin
                  a_word <= bus.input_a;
                  a_ack  <= 1'b0;
                  state  <= GET_B;
               end
            end
            GET_B: begin
               b_ack <= 1'b1;
               if (b_ack && bus.input_b_stb) begin
                  b_word <= bus.input_b;
                  rm     <= bus.input_rm;
                  b_ack  <= 1'b0;
                  state  <= UNPACK;
               end
            end
            UNPACK: begin
               a_s   <= a_word[W-1];
               a_x   <= a_word[W-2:F];
               a_f   <= a_word[F-1:0];
               b_s   <= b_word[W-1];
               b_x   <= b_word[W-2:F];
               b_f   <= b_word[F-1:0];
               state <= SPECIAL;
            end
            SPECIAL: begin
               state <= PUT_Z;
               flags <= '0;
               if (a_nan || b_nan) begin
                  z <= QNAN;
               end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
                  z     <= QNAN;
                  flags <= 5'b10000;
               end else if (a_inf) begin
                  z <= {sgn, {EXP_W{1'b1}}, {F{1'b0}}};
               end else if (b_inf || a_zero) begin
                  z <= {sgn, {(W-1){1'b0}}};
               end else if (b_zero) begin
                  z     <= {sgn, {EXP_W{1'b1}}, {F{1'b0}}};
                  flags <= 5'b01000;
               end else begin
                  m_a   <= {(a_x != '0), a_f};
                  m_b   <= {(b_x != '0), b_f};
                  a_e   <= (a_x == '0) ? EMIN : ({2'b00, a_x} - BIAS);
                  b_e   <= (b_x == '0) ? EMIN : ({2'b00, b_x} - BIAS);
                  state <= NORM_A;
               end
            end
            NORM_A: begin
               if (m_a[F]) state <= NORM_B;
               else begin
                  m_a <= m_a << 1;
                  a_e <= a_e - EW'(1);
               end
            end
            NORM_B: begin
               if (m_b[F]) state <= DIV_INIT;
               else begin
                  m_b <= m_b << 1;
                  b_e <= b_e - EW'(1);
               end
            end
            // rem starts at m_a: the all-zero leading quotient bits of
            // m_a << (F+3) are skipped, so the same Q emerges in F+4 steps.
            DIV_INIT: begin
               z_s   <= sgn;
               z_e   <= a_e - b_e;
               rem   <= {1'b0, m_a};
               q     <= '0;
               count <= '0;
               state <= DIVIDE;
            end
            DIVIDE: begin
               q     <= {q[QW-2:0], rem_ge};
               rem   <= rem_next;
               count <= count + 7'd1;
               if (count == 7'(QW - 1)) state <= DIV_DONE;
            end
            DIV_DONE: begin
               if (q[QW-1]) begin
                  mant <= q[F+3:3];
                  g    <= q[2];
                  r    <= q[1];
                  s    <= q[0] | (rem != '0);
               end else begin
                  z_e  <= z_e - EW'(1);
                  mant <= q[F+2:2];
                  g    <= q[1];
                  r    <= q[0];
                  s    <= (rem != '0);
               end
               state <= DENORM;
            end
            DENORM: begin
               if (z_e < EMIN) begin
                  mant <= mant >> 1;
                  g    <= mant[0];
                  r    <= g;
                  s    <= s | r;
                  z_e  <= z_e + EW'(1);
               end else begin
                  state <= ROUND;
               end
            end
            ROUND: begin
               inexact   <= grs;
               underflow <= grs & ~mant[F];
               if (sum[F+1]) begin
                  mant <= sum[F+1:1];
                  z_e  <= z_e + EW'(1);
               end else begin
                  mant <= sum[F:0];
               end
               state <= PACK;
            end
            PACK: begin
               if (z_e > BIAS) begin
                  z     <= sat_max ? {z_s, {(EXP_W-1){1'b1}}, 1'b0, {F{1'b1}}}
                                   : {z_s, {EXP_W{1'b1}}, {F{1'b0}}};
                  flags <= 5'b00101;
               end else begin
                  z     <= {z_s, z_exp, mant[F-1:0]};
                  flags <= {3'b000, underflow, inexact};
               end
               state <= PUT_Z;
            end
            PUT_Z: begin
               z_stb <= 1'b1;
               if (z_stb && bus.output_z_ack) begin
                  z_stb <= 1'b0;
                  state <= GET_A;
               end
            end
            default: state <= GET_A;
         endcase
      end
   end

   assign bus.input_a_ack    = a_ack;
   assign bus.input_b_ack    = b_ack;
   assign bus.output_z       = z;
   assign bus.output_z_flags = flags;
   assign bus.output_z_stb   = z_stb;
endmodule

// File: tb/tb_fp_divider_param.sv
// Bench for fp_divider_param: directed cases plus random operands checked
// against an exact rational-arithmetic division model, for two widths.
module tb_fp_divider_param;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fp_divider_param_if #(.EXP_W(8), .MAN_W(23)) bd ();
   fp_divider_param_if #(.EXP_W(5), .MAN_W(10)) bh ();

   fp_divider_param #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst(rst), .bus(bd));
   fp_divider_param #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .rst(rst), .bus(bh));

   logic        sel = 1'b0;
   logic [63:0] tb_a = '0, tb_b = '0;
   logic        tb_a_stb = 1'b0, tb_b_stb = 1'b0, tb_ack = 1'b0;
   logic [1:0]  tb_rm = 2'd0;

   assign bd.input_a      = tb_a[31:0];
   assign bd.input_b      = tb_b[31:0];
   assign bd.input_rm     = tb_rm;
   assign bd.input_a_stb  = tb_a_stb & ~sel;
   assign bd.input_b_stb  = tb_b_stb & ~sel;
   assign bd.output_z_ack = tb_ack & ~sel;
   assign bh.input_a      = tb_a[15:0];
   assign bh.input_b      = tb_b[15:0];
   assign bh.input_rm     = tb_rm;
   assign bh.input_a_stb  = tb_a_stb & sel;
   assign bh.input_b_stb  = tb_b_stb & sel;
   assign bh.output_z_ack = tb_ack & sel;

   logic        a_ack_v, b_ack_v, stb_v;
   logic [63:0] z_v;
   logic [4:0]  fl_v;
   assign a_ack_v = sel ? bh.input_a_ack : bd.input_a_ack;
   assign b_ack_v = sel ? bh.input_b_ack : bd.input_b_ack;
   assign stb_v   = sel ? bh.output_z_stb : bd.output_z_stb;
   assign z_v     = sel ? {48'd0, bh.output_z} : {32'd0, bd.output_z};
   assign fl_v    = sel ? bh.output_z_flags : bd.output_z_flags;

   int n_asserts = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Exact reference: quotient scaled to the result quantum, rounded with integer division.
   function automatic void ref_div(input logic [63:0] a, input logic [63:0] b, input logic [1:0] rm,
                                   input int ew, input int f,
                                   output logic [63:0] z, output logic [4:0] fl, output int lat);
      logic [63:0] fmask, xmask, xa, xb, fa, fb, qnan, zsw, ef;
      logic sa, sb, zs, up, inx;
      logic [127:0] ma, mb, num, den, quo, rem;
      int bias, emin, ea, eb, na, nb, ue, dn, qexp, sh;
      logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
      fmask = (64'd1 << f) - 64'd1;
      xmask = (64'd1 << ew) - 64'd1;
      bias = (1 << (ew - 1)) - 1;
      emin = 1 - bias;
      sa = a[ew+f]; sb = b[ew+f]; zs = sa ^ sb;
      xa = (a >> f) & xmask; xb = (b >> f) & xmask;
      fa = a & fmask; fb = b & fmask;
      qnan = (64'd1 << (ew + f)) | (xmask << f) | (64'd1 << (f - 1));
      zsw = {63'd0, zs} << (ew + f);
      nan_a = (xa == xmask) && (fa != 0); nan_b = (xb == xmask) && (fb != 0);
      inf_a = (xa == xmask) && (fa == 0); inf_b = (xb == xmask) && (fb == 0);
      zero_a = (xa == 0) && (fa == 0);    zero_b = (xb == 0) && (fb == 0);
      fl = 5'b0; lat = 3;
      if (nan_a || nan_b) z = qnan;
      else if ((inf_a && inf_b) || (zero_a && zero_b)) begin z = qnan; fl = 5'b10000; end
      else if (inf_a) z = zsw | (xmask << f);
      else if (inf_b || zero_a) z = zsw;
      else if (zero_b) begin z = zsw | (xmask << f); fl = 5'b01000; end
      else begin
         ma = (xa == 0) ? {64'd0, fa} : {64'd0, fa | (64'd1 << f)};
         mb = (xb == 0) ? {64'd0, fb} : {64'd0, fb | (64'd1 << f)};
         ea = (xa == 0) ? emin : int'(xa) - bias;
         eb = (xb == 0) ? emin : int'(xb) - bias;
         na = 0; nb = 0;
         while (ma < (128'd1 << f)) begin ma = ma << 1; ea--; na++; end
         while (mb < (128'd1 << f)) begin mb = mb << 1; eb--; nb++; end
         ue = ea - eb - ((ma < mb) ? 1 : 0);
         dn = (ue < emin) ? emin - ue : 0;
         lat = f + 14 + na + nb + dn;
         qexp = ((ue < emin) ? emin : ue) - f;
         sh = ea - eb - qexp;
         if (sh >= 0) begin num = ma << sh; den = mb; end
         else begin num = ma; den = mb << ((-sh > 60) ? 60 : -sh); end
         quo = num / den;
         rem = num % den;
         inx = (rem != 0);
         case (rm)
            2'd0: up = (2 * rem > den) || ((2 * rem == den) && quo[0]);
            2'd1: up = 1'b0;
            2'd2: up = !zs && inx;
            default: up = zs && inx;
         endcase
         quo = quo + {127'd0, up};
         if (quo == (128'd1 << (f + 1))) begin quo = quo >> 1; qexp++; end
         if (qexp + f > bias) begin
            fl = 5'b00101;
            if (rm == 2'd1 || (rm == 2'd2 && zs) || (rm == 2'd3 && !zs))
               z = zsw | ((xmask - 64'd1) << f) | fmask;
            else
               z = zsw | (xmask << f);
         end else begin
            fl = {3'b000, inx && (ue < emin), inx};
            ef = (quo < (128'd1 << f)) ? 64'd0 : 64'(qexp + f + bias);
            z = zsw | (ef << f) | (quo[63:0] & fmask);
         end
      end
   endfunction

   function automatic logic [63:0] rand_op(input int ew, input int f);
      logic [63:0] fmask, xmask, fr, ex;
      logic s;
      int k;
      fmask = (64'd1 << f) - 64'd1;
      xmask = (64'd1 << ew) - 64'd1;
      s = 1'($urandom_range(0, 1));
      fr = {$urandom, $urandom} & fmask;
      k = int'($urandom_range(0, 11));
      case (k)
         0: begin ex = 64'd0; fr = 64'd0; end
         1: begin ex = xmask; fr = 64'd0; end
         2: begin ex = xmask; fr = fr | 64'd1; end
         3, 4: begin ex = 64'd0; fr = (fr >> $urandom_range(0, f - 1)) | 64'd1; end
         5: ex = xmask - 64'd1 - 64'($urandom_range(0, 2));
         6: ex = 64'd1 + 64'($urandom_range(0, 2));
         default: ex = 64'($urandom_range(1, int'(xmask) - 1));
      endcase
      return ({63'd0, s} << (ew + f)) | (ex << f) | fr;
   endfunction

   task automatic send_ab(input logic s, input logic [63:0] a, input logic [63:0] b, input logic [1:0] rm);
      logic got;
      sel = s;
      tb_a = a; tb_a_stb = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); got = a_ack_v; end
      chk("a_ack_wait", {63'd0, got}, 64'd1);
      @(posedge clk); #1;
      tb_a_stb = 1'b0;
      tb_b = b; tb_rm = rm; tb_b_stb = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); got = b_ack_v; end
      chk("b_ack_wait", {63'd0, got}, 64'd1);
      @(posedge clk); #1;
      tb_b_stb = 1'b0;
   endtask

   task automatic do_op(input logic s, input logic [63:0] a, input logic [63:0] b, input logic [1:0] rm,
                        input int hold, output logic [63:0] z, output logic [4:0] fl, output int lat);
      logic got;
      send_ab(s, a, b, rm);
      lat = 0; got = 1'b0;
      while (!got && lat < 600) begin
         @(posedge clk); lat++; #1;
         got = stb_v;
      end
      if (!got) lat = -1;
      z = z_v; fl = fl_v;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_stb", {63'd0, stb_v}, 64'd1);
         chk("hold_data", z_v, z);
         chk("hold_a_ack", {63'd0, a_ack_v}, 64'd0);
      end
      @(negedge clk); tb_ack = 1'b1;
      @(posedge clk); #1; tb_ack = 1'b0;
      chk("stb_drop", {63'd0, stb_v}, 64'd0);
   endtask

   task automatic run_dir(input string tag, input logic s, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] rm, input logic [63:0] ez, input logic [4:0] efl, input int elat);
      logic [63:0] z; logic [4:0] fl; int lat;
      do_op(s, a, b, rm, 0, z, fl, lat);
      chk({tag, "_z"}, z, ez);
      chk({tag, "_flags"}, {59'd0, fl}, {59'd0, efl});
      chk({tag, "_lat"}, 64'(lat), 64'(elat));
   endtask

   task automatic run_rand(input logic s, input int ew, input int f);
      logic [63:0] a, b, z, ez; logic [4:0] fl, efl; logic [1:0] rm; int lat, elat;
      a = rand_op(ew, f); b = rand_op(ew, f); rm = 2'($urandom_range(0, 3));
      ref_div(a, b, rm, ew, f, ez, efl, elat);
      do_op(s, a, b, rm, 0, z, fl, lat);
      chk("rand_z", z, ez);
      chk("rand_flags", {59'd0, fl}, {59'd0, efl});
      chk("rand_lat", 64'(lat), 64'(elat));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] z; logic [4:0] fl; int lat;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_a_ack", {63'd0, bd.input_a_ack}, 64'd0);
      chk("rst_b_ack", {63'd0, bd.input_b_ack}, 64'd0);
      chk("rst_stb", {63'd0, bd.output_z_stb}, 64'd0);
      chk("rst_z", {32'd0, bd.output_z}, 64'd0);
      chk("rst_flags", {59'd0, bd.output_z_flags}, 64'd0);
      rst = 1'b0;

      run_dir("six_by_two", 1'b0, 64'h40C00000, 64'h40000000, 2'd0, 64'h40400000, 5'b00000, 37);
      run_dir("third_rne", 1'b0, 64'h3F800000, 64'h40400000, 2'd0, 64'h3EAAAAAB, 5'b00001, 37);
      run_dir("third_rtz", 1'b0, 64'h3F800000, 64'h40400000, 2'd1, 64'h3EAAAAAA, 5'b00001, 37);
      run_dir("third_rup", 1'b0, 64'h3F800000, 64'h40400000, 2'd2, 64'h3EAAAAAB, 5'b00001, 37);
      run_dir("third_rdn", 1'b0, 64'h3F800000, 64'h40400000, 2'd3, 64'h3EAAAAAA, 5'b00001, 37);
      run_dir("zero_zero", 1'b0, 64'h00000000, 64'h00000000, 2'd0, 64'hFFC00000, 5'b10000, 3);
      run_dir("one_zero", 1'b0, 64'h3F800000, 64'h00000000, 2'd0, 64'h7F800000, 5'b01000, 3);
      run_dir("nan_one", 1'b0, 64'h7FC00000, 64'h3F800000, 2'd0, 64'hFFC00000, 5'b00000, 3);
      run_dir("ovf_rne", 1'b0, 64'h7F7FFFFF, 64'h3F000000, 2'd0, 64'h7F800000, 5'b00101, 37);
      run_dir("ovf_rtz", 1'b0, 64'h7F7FFFFF, 64'h3F000000, 2'd1, 64'h7F7FFFFF, 5'b00101, 37);
      run_dir("sub_exact", 1'b0, 64'h00800000, 64'h40000000, 2'd0, 64'h00400000, 5'b00000, 38);
      run_dir("sub_tie", 1'b0, 64'h00000001, 64'h40000000, 2'd0, 64'h00000000, 5'b00011, 84);
      run_dir("half_third", 1'b1, 64'h3C00, 64'h4200, 2'd0, 64'h3555, 5'b00001, 24);

      do_op(1'b0, 64'h40C00000, 64'h40000000, 2'd0, 10, z, fl, lat);
      chk("bp_z", z, 64'h40400000);

      send_ab(1'b0, 64'h40C00000, 64'h40000000, 2'd0);
      repeat (12) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_a_ack", {63'd0, bd.input_a_ack}, 64'd0);
      chk("mid_rst_b_ack", {63'd0, bd.input_b_ack}, 64'd0);
      chk("mid_rst_stb", {63'd0, bd.output_z_stb}, 64'd0);
      chk("mid_rst_z", {32'd0, bd.output_z}, 64'd0);
      @(negedge clk); rst = 1'b0;
      run_dir("after_rst", 1'b0, 64'h40C00000, 64'h40000000, 2'd0, 64'h40400000, 5'b00000, 37);

      for (int i = 0; i < 60; i++) run_rand(1'b0, 8, 23);
      for (int i = 0; i < 30; i++) run_rand(1'b1, 5, 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
